// File: rtl/axi4_lite_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi4_lite_cmd_master                                         |
// | Description : Single-command request/response port to AXI4-Lite master.    |
// |               One transaction outstanding at a time; every accepted        |
// |               command produces exactly one response. Saturating 16-bit     |
// |               counter of error responses.                                  |
// | Ports       : aclk/aresetn      clock, async active-low reset              |
// |               cmd_*             command request (valid/ready)               |
// |               rsp_*             response (valid/ready), rdata, resp, err    |
// |               err_cnt           saturating error-response count            |
// |               m_axi_*           AXI4-Lite master channels (AW/W/B/AR/R)     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axi4_lite_cmd_master #(
  parameter int         AW   = 32,
  parameter int         DW   = 64,
  parameter logic [2:0] PROT = 3'b000
) (
  input  logic            aclk,
  input  logic            aresetn,
  // command port
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [DW/8-1:0] cmd_wstrb,
  // response port
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic [1:0]      rsp_resp,
  output logic            rsp_err,
  output logic [15:0]     err_cnt,
  // AXI4-Lite master side
  output logic [AW-1:0]   m_axi_awaddr,
  output logic [2:0]      m_axi_awprot,
  output logic            m_axi_awvalid,
  input  logic            m_axi_awready,
  output logic [DW-1:0]   m_axi_wdata,
  output logic [DW/8-1:0] m_axi_wstrb,
  output logic            m_axi_wvalid,
  input  logic            m_axi_wready,
  input  logic [2:0]      m_axi_bresp,
  input  logic            m_axi_bvalid,
  output logic            m_axi_bready,
  output logic [AW-1:0]   m_axi_araddr,
  output logic [2:0]      m_axi_arprot,
  output logic            m_axi_arvalid,
  input  logic            m_axi_arready,
  input  logic [DW-1:0]   m_axi_rdata,
  input  logic [1:0]      m_axi_rresp,
  input  logic            m_axi_rvalid,
  output logic            m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    RSP          = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW/8-1:0]   wstrb_q, wstrb_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              resp_capture;

  // bresp[2] carries no meaning for this initiator.
  logic              bresp_unused;
  assign bresp_unused = m_axi_bresp[2];

  // All handshake-side outputs decode registered state only, so no AXI output
  // has a combinational path from an AXI input. cmd_ready is also masked by
  // reset so it reads 0 while aresetn is held low.
  assign cmd_ready     = (state_q == IDLE) && aresetn;
  assign m_axi_awvalid = (state_q == WR_ADDR_DATA) && !aw_done_q;
  assign m_axi_wvalid  = (state_q == WR_ADDR_DATA) && !w_done_q;
  assign m_axi_bready  = (state_q == WR_RESP);
  assign m_axi_arvalid = (state_q == RD_ADDR);
  assign m_axi_rready  = (state_q == RD_DATA);
  assign rsp_valid     = (state_q == RSP);

  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_awprot  = PROT;
  assign m_axi_arprot  = PROT;

  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_err       = (resp_q != 2'b00);
  assign err_cnt       = err_cnt_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    rdata_d      = rdata_q;
    resp_d       = resp_q;
    err_cnt_d    = err_cnt_q;
    resp_capture = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_we ? WR_ADDR_DATA : RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        // Each channel retires on its own; once retired its valid stays low
        // for the rest of this command. Leave as soon as both have retired.
        aw_done_d = aw_done_q || (m_axi_awvalid && m_axi_awready);
        w_done_d  = w_done_q  || (m_axi_wvalid  && m_axi_wready);
        if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          resp_d       = m_axi_bresp[1:0];
          rdata_d      = '0;
          resp_capture = 1'b1;
          state_d      = RSP;
        end
      end
      RD_ADDR: begin
        if (m_axi_arready) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          resp_d       = m_axi_rresp;
          rdata_d      = m_axi_rdata;
          resp_capture = 1'b1;
          state_d      = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counted on the capturing edge only, so a response parked in RSP under
    // backpressure is counted exactly once.
    if (resp_capture && (resp_d != 2'b00) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      err_cnt_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axi4_lite_cmd_master                                      |
// | Description : Self-checking bench for axi4_lite_cmd_master. A delay-       |
// |               configurable AXI4-Lite slave answers every transaction; a    |
// |               table of directed vectors and a randomized phase are checked |
// |               against expectations derived from the command/response rules.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_axi4_lite_cmd_master;

  localparam int         AW      = 32;
  localparam int         DW      = 64;
  localparam logic [2:0] TB_PROT = 3'b101;

  logic          clk;
  logic          aresetn;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [31:0]   cmd_addr;
  logic [63:0]   cmd_wdata;
  logic [7:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [63:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [15:0]   err_cnt;
  logic [31:0]   m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [63:0]   m_axi_wdata, m_axi_rdata;
  logic [7:0]    m_axi_wstrb;
  logic [2:0]    m_axi_bresp;
  logic          m_axi_bvalid, m_axi_bready;
  logic          m_axi_arvalid, m_axi_arready;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rvalid, m_axi_rready;

  int n_checks = 0;
  int n_errors = 0;

  axi4_lite_cmd_master #(.AW(AW), .DW(DW), .PROT(TB_PROT)) dut (
    .aclk(clk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_err(rsp_err), .err_cnt(err_cnt),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (checks %0d)", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- slave ---
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [2:0]  b_cfg = 3'b000;
  logic [1:0]  r_cfg = 2'b00;
  logic [63:0] rd_cfg = 64'h0;
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  int          aw_vc = 0, w_vc = 0, ar_vc = 0;
  logic [31:0] log_awaddr, log_araddr;
  logic [63:0] log_wdata;
  logic [7:0]  log_wstrb;
  logic [2:0]  log_awprot, log_arprot;
  bit          aw_got, w_got, ar_got;
  bit          hs_aw, hs_w, hs_b, hs_ar, hs_r;
  bit          hold_aw, hold_w, hold_ar;
  logic [31:0] held_awaddr, held_araddr;
  logic [63:0] held_wdata;
  logic [7:0]  held_wstrb;
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait;

  // Everything below runs on the falling edge: handshakes computed at one
  // falling edge complete on the following rising edge and are consumed at
  // the next falling edge.
  initial begin : slave
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
        m_axi_bresp = 3'b000; m_axi_rresp = 2'b00; m_axi_rdata = 64'h0;
        aw_got = 0; w_got = 0; ar_got = 0;
        hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
        hold_aw = 0; hold_w = 0; hold_ar = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      end else begin
        if (hold_aw) chk("aw_stable", {m_axi_awvalid, m_axi_awaddr}, {1'b1, held_awaddr});
        if (hold_w)  chk("w_stable", {m_axi_wvalid, m_axi_wdata, m_axi_wstrb}, {1'b1, held_wdata, held_wstrb});
        if (hold_ar) chk("ar_stable", {m_axi_arvalid, m_axi_araddr}, {1'b1, held_araddr});

        if (hs_aw) begin aw_got = 1; n_aw++; end
        if (hs_w)  begin w_got = 1;  n_w++;  end
        if (hs_b)  begin m_axi_bvalid = 0; aw_got = 0; w_got = 0; b_wait = 0; n_b++; end
        if (hs_ar) begin ar_got = 1; n_ar++; end
        if (hs_r)  begin m_axi_rvalid = 0; ar_got = 0; r_wait = 0; n_r++; end

        if (aw_got) chk("aw_reraised", m_axi_awvalid, 1'b0);
        if (w_got)  chk("w_reraised", m_axi_wvalid, 1'b0);
        if (ar_got) chk("ar_reraised", m_axi_arvalid, 1'b0);
        if (m_axi_bready) chk("bready_before_aw_w", {aw_got, w_got}, 2'b11);
        if (m_axi_rready) chk("rready_before_ar", ar_got, 1'b1);

        if (m_axi_awvalid) aw_vc++;
        if (m_axi_wvalid)  w_vc++;
        if (m_axi_arvalid) ar_vc++;

        m_axi_awready = 0;
        if (m_axi_awvalid && !aw_got) begin
          if (aw_wait >= aw_dly) begin
            m_axi_awready = 1; aw_wait = 0;
            log_awaddr = m_axi_awaddr; log_awprot = m_axi_awprot;
          end else aw_wait++;
        end
        m_axi_wready = 0;
        if (m_axi_wvalid && !w_got) begin
          if (w_wait >= w_dly) begin
            m_axi_wready = 1; w_wait = 0;
            log_wdata = m_axi_wdata; log_wstrb = m_axi_wstrb;
          end else w_wait++;
        end
        m_axi_arready = 0;
        if (m_axi_arvalid && !ar_got) begin
          if (ar_wait >= ar_dly) begin
            m_axi_arready = 1; ar_wait = 0;
            log_araddr = m_axi_araddr; log_arprot = m_axi_arprot;
          end else ar_wait++;
        end
        if (aw_got && w_got && !m_axi_bvalid) begin
          if (b_wait >= b_dly) begin m_axi_bvalid = 1; m_axi_bresp = b_cfg; end
          else b_wait++;
        end
        if (ar_got && !m_axi_rvalid) begin
          if (r_wait >= r_dly) begin m_axi_rvalid = 1; m_axi_rresp = r_cfg; m_axi_rdata = rd_cfg; end
          else r_wait++;
        end

        hs_aw = m_axi_awvalid && m_axi_awready;
        hs_w  = m_axi_wvalid  && m_axi_wready;
        hs_b  = m_axi_bvalid  && m_axi_bready;
        hs_ar = m_axi_arvalid && m_axi_arready;
        hs_r  = m_axi_rvalid  && m_axi_rready;
        hold_aw = m_axi_awvalid && !m_axi_awready; held_awaddr = m_axi_awaddr;
        hold_w  = m_axi_wvalid  && !m_axi_wready;  held_wdata = m_axi_wdata; held_wstrb = m_axi_wstrb;
        hold_ar = m_axi_arvalid && !m_axi_arready; held_araddr = m_axi_araddr;
      end
    end
  end

  // -------------------------------------------------------------- vectors ---
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [2:0]  bresp;
    logic [1:0]  rresp;
    logic [63:0] rdata;
    int          hold;
    bit          poke;
    int          exp_lat;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  logic [15:0] model_cnt = 16'h0;

  function automatic vec_t mk(logic we, logic [31:0] a, logic [63:0] d, logic [7:0] s,
                              int awd, int wd, int bd, int ard, int rd,
                              logic [2:0] br, logic [1:0] rr, logic [63:0] rdat,
                              int hold, bit poke, int lat, logic [63:0] erd,
                              logic [1:0] ers, logic eer, logic [15:0] ecnt);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d; v.wstrb = s;
    v.aw_d = awd; v.w_d = wd; v.b_d = bd; v.ar_d = ard; v.r_d = rd;
    v.bresp = br; v.rresp = rr; v.rdata = rdat; v.hold = hold; v.poke = poke;
    v.exp_lat = lat; v.exp_rdata = erd; v.exp_resp = ers; v.exp_err = eer; v.exp_cnt = ecnt;
    return v;
  endfunction

  // Reference: response content and timing follow from the command type and
  // the slave's configured delays; the error counter saturates at 0xFFFF.
  task automatic finish_model(inout vec_t v);
    if (v.we) begin
      v.exp_lat   = 3 + ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + v.b_d;
      v.exp_rdata = 64'h0;
      v.exp_resp  = v.bresp[1:0];
    end else begin
      v.exp_lat   = 3 + v.ar_d + v.r_d;
      v.exp_rdata = v.rdata;
      v.exp_resp  = v.rresp;
    end
    v.exp_err = (v.exp_resp != 2'b00);
    if (v.exp_err && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
    v.exp_cnt = model_cnt;
  endtask

  task automatic build_rand(output vec_t v);
    v.we    = 1'($urandom_range(0, 1));
    v.addr  = $urandom;
    v.wdata = {$urandom, $urandom};
    v.wstrb = 8'($urandom_range(0, 255));
    v.aw_d  = $urandom_range(0, 3);
    v.w_d   = $urandom_range(0, 3);
    v.b_d   = $urandom_range(0, 3);
    v.ar_d  = $urandom_range(0, 3);
    v.r_d   = $urandom_range(0, 3);
    v.bresp = 3'($urandom_range(0, 7));
    v.rresp = 2'($urandom_range(0, 3));
    v.rdata = {$urandom, $urandom};
    v.hold  = $urandom_range(0, 2);
    v.poke  = 0;
    finish_model(v);
  endtask

  // Issue one command from an IDLE falling edge and check the whole exchange.
  task automatic run_txn(input vec_t v);
    int lat, g;
    int aw0, w0, b0, ar0, r0, awc0, wc0, arc0;
    aw_dly = v.aw_d; w_dly = v.w_d; b_dly = v.b_d; ar_dly = v.ar_d; r_dly = v.r_d;
    b_cfg = v.bresp; r_cfg = v.rresp; rd_cfg = v.rdata;
    aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
    awc0 = aw_vc; wc0 = w_vc; arc0 = ar_vc;
    cmd_valid = 1; cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    g = 0;
    while (!cmd_ready && g < 20) begin @(negedge clk); g++; end
    chk("cmd_accept", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 64) begin @(negedge clk); lat++; end
    chk("rsp_latency", lat, v.exp_lat);
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_resp", rsp_resp, v.exp_resp);
    chk("rsp_err", rsp_err, v.exp_err);
    chk("err_cnt", err_cnt, v.exp_cnt);
    chk("cmd_ready_busy", cmd_ready, 1'b0);
    for (int i = 0; i < v.hold; i++) begin
      if (v.poke) begin
        cmd_valid = 1; cmd_we = ~v.we; cmd_addr = 32'hBAD0_0000;
      end
      @(negedge clk);
      chk("hold_rsp", {rsp_valid, rsp_rdata, rsp_resp, rsp_err}, {1'b1, v.exp_rdata, v.exp_resp, v.exp_err});
      chk("hold_cmd_ready", cmd_ready, 1'b0);
      chk("hold_no_new_axi", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
      chk("hold_err_cnt", err_cnt, v.exp_cnt);
    end
    cmd_valid = 0;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("idle_after_rsp", {cmd_ready, rsp_valid}, 2'b10);
    if (v.we) begin
      chk("wr_hs_counts", {n_aw - aw0, n_w - w0, n_b - b0, n_ar - ar0, n_r - r0},
          {32'd1, 32'd1, 32'd1, 32'd0, 32'd0});
      chk("awvalid_cycles", aw_vc - awc0, v.aw_d + 1);
      chk("wvalid_cycles", w_vc - wc0, v.w_d + 1);
      chk("awaddr", log_awaddr, v.addr);
      chk("wdata_wstrb", {log_wdata, log_wstrb}, {v.wdata, v.wstrb});
      chk("awprot", log_awprot, TB_PROT);
    end else begin
      chk("rd_hs_counts", {n_aw - aw0, n_w - w0, n_b - b0, n_ar - ar0, n_r - r0},
          {32'd0, 32'd0, 32'd0, 32'd1, 32'd1});
      chk("arvalid_cycles", ar_vc - arc0, v.ar_d + 1);
      chk("araddr", log_araddr, v.addr);
      chk("arprot", log_arprot, TB_PROT);
    end
  endtask

  // ----------------------------------------------------------------- main ---
  initial begin : main
    vec_t tbl[7];
    vec_t v;
    //            we    addr          wdata                  strb  aw w b ar r  bresp   rresp  rdata                  hold poke lat exp_rdata             resp  err cnt
    tbl[0] = mk(1'b1, 32'h0000_0010, 64'hDEADBEEF_01234567, 8'hFF, 0, 0, 0, 0, 0, 3'b000, 2'b00, 64'h0,                 0, 0, 3, 64'h0,                 2'b00, 0, 16'd0);
    tbl[1] = mk(1'b0, 32'h0000_0020, 64'h0,                 8'h00, 0, 0, 0, 4, 2, 3'b000, 2'b00, 64'hCAFE,              6, 1, 9, 64'hCAFE,              2'b00, 0, 16'd0);
    tbl[2] = mk(1'b1, 32'h1000_0004, 64'h11223344_55667788, 8'h0F, 4, 0, 0, 0, 0, 3'b000, 2'b00, 64'h0,                 0, 0, 7, 64'h0,                 2'b00, 0, 16'd0);
    tbl[3] = mk(1'b1, 32'h0000_0040, 64'hA5A5A5A5_5A5A5A5A, 8'h81, 0, 0, 1, 0, 0, 3'b010, 2'b00, 64'h0,                 1, 0, 4, 64'h0,                 2'b10, 1, 16'd1);
    tbl[4] = mk(1'b0, 32'h0000_0044, 64'h0,                 8'h00, 0, 0, 0, 0, 0, 3'b000, 2'b11, 64'h0123,              0, 0, 3, 64'h0123,              2'b11, 1, 16'd2);
    tbl[5] = mk(1'b1, 32'h0000_0048, 64'h0F0F0F0F_F0F0F0F0, 8'h3C, 2, 3, 0, 0, 0, 3'b100, 2'b00, 64'h0,                 2, 0, 6, 64'h0,                 2'b00, 0, 16'd2);
    tbl[6] = mk(1'b0, 32'h0000_004C, 64'h0,                 8'h00, 0, 0, 0, 1, 0, 3'b000, 2'b01, 64'hFFFF0000_AAAA5555, 0, 0, 4, 64'hFFFF0000_AAAA5555, 2'b01, 1, 16'd3);

    aresetn = 0; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1'b0);
    chk("reset_axi_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 5'b0);
    chk("reset_rsp", {rsp_valid, rsp_rdata, rsp_resp, rsp_err, err_cnt}, 128'h0);
    aresetn = 1;
    #1;
    chk("cmd_ready_after_reset", cmd_ready, 1'b1);
    @(negedge clk);

    foreach (tbl[i]) run_txn(tbl[i]);
    model_cnt = 16'd3;

    for (int i = 0; i < 40; i++) begin
      build_rand(v);
      run_txn(v);
    end

    // Saturation: preload one below the limit, then two more errors.
    force dut.err_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.err_cnt_q;
    model_cnt = 16'hFFFE;
    v = mk(1'b1, 32'h0000_0080, 64'h1, 8'h01, 0, 0, 0, 0, 0, 3'b011, 2'b00, 64'h0, 0, 0, 0, 64'h0, 2'b00, 0, 16'h0);
    finish_model(v);
    run_txn(v);
    v = mk(1'b0, 32'h0000_0084, 64'h0, 8'h00, 0, 0, 0, 0, 0, 3'b000, 2'b10, 64'h77, 1, 0, 0, 64'h0, 2'b00, 0, 16'h0);
    finish_model(v);
    run_txn(v);
    chk("err_cnt_saturated", err_cnt, 16'hFFFF);

    // Reset while the write address/data are still being offered.
    aw_dly = 20; w_dly = 20; b_dly = 0;
    cmd_valid = 1; cmd_we = 1; cmd_addr = 32'h0000_00C0; cmd_wdata = 64'h5; cmd_wstrb = 8'hFF;
    @(negedge clk);
    cmd_valid = 0;
    chk("mid_awvalid_up", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    #2 aresetn = 0;
    #1;
    chk("mid_rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid}, 6'b0);
    chk("mid_rst_err_cnt", err_cnt, 16'h0);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    aresetn = 1;
    model_cnt = 16'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {rsp_valid, m_axi_awvalid, m_axi_wvalid, cmd_ready}, 4'b0001);
    end
    v = mk(1'b0, 32'h0000_00D0, 64'h0, 8'h00, 0, 0, 0, 1, 1, 3'b000, 2'b00, 64'h1234_5678, 0, 0, 0, 64'h0, 2'b00, 0, 16'h0);
    finish_model(v);
    run_txn(v);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi4_lite_cmd_master.md
Name: axi4_lite_cmd_master

Overview:
- Initiator end of the team's axi4_lite_if. Converts a simple single-command request/response port into AXI4-Lite read or write transactions on the interface's m modport.
- Used by internal control logic (sequencers, config loaders) to reach AXI4-Lite register slaves.
- Exactly one outstanding transaction at a time. A response is returned for every command.
- Saturating error counter for diagnostics.

Parameters:
- AW, 32, address width; must match the connected axi4_lite_if.
- DW, 64, data width; must match the connected axi4_lite_if. Strobe width is DW/8.
- PROT, 3'b000, constant value driven on awprot/arprot.

Ports:
- aclk  in  1  clock; all logic is rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  byte address; passed unmodified.
- cmd_wdata  in  DW  write data.
- cmd_wstrb  in  DW/8  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DW  read data; 0 for writes.
- rsp_resp  out  2  bresp[1:0] or rresp of the completed transaction.
- rsp_err  out  1  rsp_resp != 2'b00.
- err_cnt  out  16  count of error responses; saturates at 16'hFFFF.
- m_axi  axi4_lite_if.m  AXI4-Lite master side.

Behaviour:
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- Reset (async assert, sync release):
  - State IDLE.
  - awvalid, wvalid, arvalid, bready, rready, rsp_valid = 0.
  - rsp_rdata, rsp_resp, rsp_err, err_cnt = 0.
  - cmd_ready = 0 during reset, 1 in the first IDLE cycle after reset.
- Reset mid-transaction: all valids/readies drop immediately. The in-flight command is lost and no response is produced.
- cmd_ready = 1 only in IDLE (combinational from state). On acceptance, register addr/wdata/wstrb/we.
- awaddr/araddr/wdata/wstrb come from these registers and stay stable while their valid is high. awprot = arprot = PROT.
- WR_ADDR_DATA:
  - awvalid and wvalid both go high the cycle after acceptance.
  - Each drops independently in the cycle after its own handshake, and is never re-raised for the same command.
  - Either order, or a simultaneous handshake, is legal.
  - Go to WR_RESP once both handshakes have completed. A transition on the same edge as the last handshake is allowed.
- WR_RESP:
  - bready = 1.
  - On bvalid: capture bresp[1:0]; bresp[2] is ignored. Set rsp_rdata = 0 and go to RSP.
- RD_ADDR: arvalid = 1 until arready. On handshake go to RD_DATA; arvalid is 0 in the next cycle.
- RD_DATA:
  - rready = 1.
  - On rvalid: capture rdata/rresp and go to RSP.
- RSP:
  - rsp_valid = 1. rsp_* stay stable until rsp_ready, then go to IDLE.
  - rsp_ready may be high on the first RSP cycle, giving a 1-cycle RSP.
- No valid is ever deasserted before its handshake; no AXI output depends combinationally on an AXI input.
- Error counting:
  - err_cnt increments by 1 on the edge that captures a response with resp != 0, i.e. entry to RSP. It counts once per transaction.
  - At 16'hFFFF it holds.
- Minimum latency with an always-ready slave:
  - Write: accept at cycle 0, aw/w handshake at cycle 1, b at cycle 2, rsp_valid at cycle 3. cmd_ready is high again at cycle 4 if rsp_ready was 1 at cycle 3.
  - Read: ar at cycle 1, r at cycle 2, rsp_valid at cycle 3.
- cmd_valid while not in IDLE: ignored (cmd_ready = 0). No queuing.

Test Plan:
- Write, instant slave: cmd_we=1, addr=0x10, wdata=0xDEADBEEF_01234567, wstrb=0xFF -> awaddr=0x10 and wdata/wstrb appear at cycle 1; rsp_valid at cycle 3 with rsp_resp=0, rsp_err=0, rsp_rdata=0.
- Read with delays: arready 4 cycles late, rvalid 3 cycles after the handshake with rdata=0xCAFE, rresp=0 -> arvalid held stable for 5 cycles; rsp_rdata=0xCAFE; address stable throughout.
- Split write handshakes: wready at cycle 1, awready at cycle 5 -> wvalid low from cycle 2; awvalid high through cycle 5; bready asserted only after cycle 5; a single response.
- Errors: write with bresp=3'b010, then read with rresp=2'b11 -> rsp_err=1 for both; err_cnt=2. Preload err_cnt to 0xFFFF via repeated errors (or force) -> stays 0xFFFF after another error.
- Backpressure: rsp_ready=0 for 6 cycles -> rsp_* stable, cmd_ready=0, a new cmd_valid is not accepted. rsp_ready=1 -> IDLE the next cycle.
- Reset mid-transaction: assert aresetn=0 while awvalid=1 -> all valids 0 immediately, err_cnt=0, no rsp_valid. After release, the next read completes normally.
